// File: rtl/run_controller_pkg.sv
// run_ctrl_pkg: shared types and constants for the run controller.
// FSM state encoding, run status codes, core-count limits and the helper
// that validates a requested core count.
package run_ctrl_pkg;

    localparam int NCORES_MAX = 16;
    localparam int CORE_CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LAUNCH = 2'b01,
        ST_RUN    = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        STAT_NONE    = 2'b00,
        STAT_OK      = 2'b01,
        STAT_TIMEOUT = 2'b10,
        STAT_ABORT   = 2'b11
    } status_t;

    // A requested core count is usable when it names at least one core and
    // no more cores than this instance controls.
    function automatic logic count_valid(input logic [CORE_CNT_W-1:0] n, input int ncores);
        return (n != '0) && (int'(n) <= ncores);
    endfunction

endpackage

// File: rtl/run_controller_if.sv
// run_controller_if: host-side bundle of the run controller.
// The master modport is the host that launches runs and owns the cores'
// end-of-program flags; the slave modport is the controller itself.
interface run_controller_if #(
    parameter int NCORES = 16,
    parameter int CNT_W  = 32
);

    logic              start;
    logic              abort;
    logic [4:0]        num_cores_in;
    logic [NCORES-1:0] op_end;
    logic [3:0]        rd_sel;

    logic [NCORES-1:0] core_en;
    logic [4:0]        num_cores;
    logic              busy;
    logic              done;
    logic [1:0]        status;
    logic              cfg_err;
    logic [CNT_W-1:0]  cycle_count;
    logic [CNT_W-1:0]  rd_cycle;

    modport master (
        output start, abort, num_cores_in, op_end, rd_sel,
        input  core_en, num_cores, busy, done, status, cfg_err, cycle_count, rd_cycle
    );

    modport slave (
        input  start, abort, num_cores_in, op_end, rd_sel,
        output core_en, num_cores, busy, done, status, cfg_err, cycle_count, rd_cycle
    );

endinterface

// File: rtl/run_controller_core_mask_gen.sv
// core_mask_gen: thermometer decode of a core count into a per-core
// enable mask, bits [count-1:0] set.
module core_mask_gen #(
    parameter int NCORES = 16
) (
    input  logic [4:0]        count,
    output logic [NCORES-1:0] mask
);

    // Each core is enabled when its index lies below the requested count.
    always_comb begin
        mask = '0;
        for (int i = 0; i < NCORES; i++) begin
            mask[i] = (i < int'(count));
        end
    end

endmodule

// File: rtl/run_controller.sv
// run_controller: launches a run on a group of cores, counts RUN cycles and
// ends the run on completion of all enabled cores, timeout or abort.
// Optional feature macro RUN_CTRL_PERF_EN adds per-core finish-cycle
// capture registers read through rd_sel/rd_cycle; without it rd_cycle is 0.
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int NCORES  = 16,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 0
) (
    input  logic           clk,
    input  logic           rst,
    run_controller_if.slave bus
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state;
    state_t            state_next;
    status_t           status_q;
    status_t           end_status;
    logic [NCORES-1:0] core_en_q;
    logic [NCORES-1:0] run_mask;
    logic [4:0]        num_cores_q;
    logic [CNT_W-1:0]  cycle_count_q;
    logic              cfg_err_q;
    logic              accept;
    logic              reject;
    logic              enter_run;
    logic              end_run;
    logic              completion;
    logic              timeout_hit;
    logic [CNT_W-1:0]  rd_cycle_w;

    core_mask_gen #(.NCORES(NCORES)) u_mask (
        .count (num_cores_q),
        .mask  (run_mask)
    );

    assign completion  = &(bus.op_end | ~core_en_q);
    assign timeout_hit = (TIMEOUT != 0) && (cycle_count_q == TIMEOUT_LAST);

    // State register; reset returns to IDLE from any state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state decode; abort beats timeout, which beats completion.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        reject     = 1'b0;
        enter_run  = 1'b0;
        end_run    = 1'b0;
        end_status = STAT_NONE;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (count_valid(bus.num_cores_in, NCORES)) begin
                        accept     = 1'b1;
                        state_next = ST_LAUNCH;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            ST_LAUNCH: begin
                if (bus.abort) begin
                    end_run    = 1'b1;
                    end_status = STAT_ABORT;
                    state_next = ST_DONE;
                end else begin
                    enter_run  = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    end_run    = 1'b1;
                    end_status = STAT_ABORT;
                end else if (timeout_hit) begin
                    end_run    = 1'b1;
                    end_status = STAT_TIMEOUT;
                end else if (completion) begin
                    end_run    = 1'b1;
                    end_status = STAT_OK;
                end
                if (end_run) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Run bookkeeping: latched count, saturating cycle counter, enables, status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_cores_q   <= '0;
            cycle_count_q <= '0;
            core_en_q     <= '0;
            status_q      <= STAT_NONE;
            cfg_err_q     <= 1'b0;
        end else begin
            cfg_err_q <= reject;
            if (accept) begin
                num_cores_q   <= bus.num_cores_in;
                cycle_count_q <= '0;
                status_q      <= STAT_NONE;
            end
            if (state == ST_RUN && cycle_count_q != '1) begin
                cycle_count_q <= cycle_count_q + 1'b1;
            end
            if (enter_run) begin
                core_en_q <= run_mask;
            end else if (end_run) begin
                core_en_q <= '0;
            end
            if (end_run) begin
                status_q <= end_status;
            end
        end
    end

`ifdef RUN_CTRL_PERF_EN
    logic [CNT_W-1:0]  perf_cycle [NCORES];
    logic [NCORES-1:0] perf_seen;

    // Record the cycle on which each enabled core first reports its end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_seen <= '0;
            for (int i = 0; i < NCORES; i++) perf_cycle[i] <= '0;
        end else if (accept) begin
            perf_seen <= '0;
            for (int i = 0; i < NCORES; i++) perf_cycle[i] <= '0;
        end else if (state == ST_RUN) begin
            for (int i = 0; i < NCORES; i++) begin
                if (bus.op_end[i] && core_en_q[i] && !perf_seen[i]) begin
                    perf_seen[i]  <= 1'b1;
                    perf_cycle[i] <= cycle_count_q;
                end
            end
        end
    end

    // Combinational read port; selects beyond the core count read as zero.
    always_comb begin
        rd_cycle_w = '0;
        if (int'(bus.rd_sel) < NCORES) rd_cycle_w = perf_cycle[bus.rd_sel];
    end
`else
    assign rd_cycle_w = '0;
`endif

    assign bus.core_en     = core_en_q;
    assign bus.num_cores   = num_cores_q;
    assign bus.busy        = (state != ST_IDLE);
    assign bus.done        = (state == ST_DONE);
    assign bus.status      = status_q;
    assign bus.cfg_err     = cfg_err_q;
    assign bus.cycle_count = cycle_count_q;
    assign bus.rd_cycle    = rd_cycle_w;

endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 SHALL have parameter NCORES, default 16, giving the number of cores controlled (1..16).
REQ-002 SHALL have parameter CNT_W, default 32, giving the cycle counter width.
REQ-003 SHALL have parameter TIMEOUT, default 0, giving the RUN cycle limit; 0 disables the timeout.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 start  in  1  launch request, sampled in IDLE only.
REQ-007 abort  in  1  forced stop, honoured in LAUNCH and RUN.
REQ-008 num_cores_in  in  5  requested core count, valid 1..NCORES.
REQ-009 op_end  in  NCORES  per-core end-of-program flags, high = core finished.
REQ-010 core_en  out  NCORES  per-core enable, for clock gating and request masking.
REQ-011 num_cores  out  5  latched core count of the current or last run.
REQ-012 busy  out  1  high in LAUNCH, RUN and DONE.
REQ-013 done  out  1  one-cycle pulse at run end.
REQ-014 status  out  2  00 none, 01 ok, 10 timeout, 11 aborted; held until next accepted start.
REQ-015 cfg_err  out  1  one-cycle pulse when start is rejected.
REQ-016 cycle_count  out  CNT_W  RUN cycles of the current or last run.
REQ-017 rd_sel  in  4  and rd_cycle  out  CNT_W: per-core finish-cycle read port (see Configuration).

Function
REQ-018 SHALL implement states IDLE, LAUNCH, RUN, DONE.
REQ-019 IDLE: core_en=0; start=1 with num_cores_in in 1..NCORES -> latch num_cores, clear cycle_count and status, go LAUNCH next edge.
REQ-020 IDLE: start=1 with num_cores_in=0 or >NCORES -> stay IDLE, cfg_err=1 for one cycle, no other output changes.
REQ-021 LAUNCH: lasts one cycle; core_en becomes the thermometer mask with bits [num_cores-1:0] set, registered on entry to RUN.
REQ-022 RUN: cycle_count increments by 1 each cycle and saturates at all-ones with no wrap.
REQ-023 RUN: completion = AND over bits of (op_end | ~core_en); when completion=1 go DONE with status 01; disabled cores are ignored.
REQ-024 RUN: when TIMEOUT!=0 and cycle_count==TIMEOUT-1 without completion, go DONE with status 10.
REQ-025 abort=1 in LAUNCH or RUN -> go DONE with status 11; abort takes priority over completion and timeout in the same cycle, and timeout takes priority over completion.
REQ-026 DONE: core_en=0, done=1 for exactly this cycle, cycle_count held, then IDLE.
REQ-027 start while busy SHALL be ignored, with no cfg_err; abort in IDLE or DONE SHALL be ignored.
REQ-028 Latency: start accepted at edge E -> core_en valid after E+1 -> first counted cycle is the cycle following E+1.
REQ-029 op_end changes outside RUN SHALL have no effect.

Reset
REQ-030 rst SHALL force IDLE, core_en=0, num_cores=0, busy=0, done=0, cfg_err=0, status=00, cycle_count=0 and all finish-cycle registers to 0, asynchronously and at any state.
REQ-031 Reset mid-RUN SHALL drop core_en immediately and SHALL NOT produce a done pulse.

Configuration
REQ-032 Macro RUN_CTRL_PERF_EN: when defined, a CNT_W register per core captures cycle_count on the first RUN cycle its op_end is high while enabled; rd_cycle = register[rd_sel], combinational; rd_sel >= NCORES returns 0.
REQ-033 With RUN_CTRL_PERF_EN defined, the capture registers SHALL be cleared on an accepted start and SHALL be held after DONE.
REQ-034 Without RUN_CTRL_PERF_EN: no capture registers; rd_cycle SHALL be constant 0; all other behaviour is identical.

Structure
REQ-035 Package run_ctrl_pkg SHALL hold the state enum, the status codes (STAT_NONE/OK/TIMEOUT/ABORT) and NCORES_MAX=16.
REQ-036 The thermometer decode SHALL be the sub-module core_mask_gen (5-bit count -> NCORES-bit mask).

Verification
REQ-037 Scenario: start, num_cores_in=4; op_end[3:0] set at RUN cycle 10 -> core_en=0x000F, done once, status=01, cycle_count=11.
REQ-038 Scenario: num_cores_in=0, then 17 -> two cfg_err pulses, state stays IDLE, core_en=0.
REQ-039 Scenario: TIMEOUT=20, num_cores_in=2, op_end=0 -> done after 20 RUN cycles, status=10, cycle_count=20.
REQ-040 Scenario: abort and completion in the same RUN cycle -> status=11; start while busy -> ignored.
REQ-041 Scenario: rst asserted mid-RUN -> core_en=0 asynchronously, no done, status=00.
REQ-042 Scenario (PERF_EN): core1 ends at cycle 5, core0 at cycle 9 -> rd_sel=1 returns 5, rd_sel=0 returns 9.
